div_recon: RTL

DIV_RECON -- requirements
Module: div_recon

---
 rtl/div_recon.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/div_recon.sv
// ---------------------------------------------------------------------------
// div_recon : reconstructs a dividend from its quotient, divisor and remainder
//             A = Q*B + R, using a bit-serial shift-and-add multiplier.
//
// A request is accepted from IDLE when in_valid is high. Eight CALC cycles
// follow, one per quotient bit. One DONE cycle then publishes the result.
// That gives a fixed latency of 9 cycles from acceptance to out_valid, and a
// back-to-back period of 10 cycles. Requests that arrive while busy are
// dropped.
//
// Optional feature (compile-time macro):
//   CONSISTENCY_CHECK_EN - adds the err output. err is set at result time
//                          when R >= B, including B == 0. The flag is valid
//                          with out_valid and holds until the next result.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous reset, active high
//   in_valid   in   1   request strobe
//   Q          in   8   quotient operand (unsigned)
//   B          in   8   divisor operand (unsigned)
//   R          in   8   remainder operand (unsigned)
//   A          out  16  reconstructed dividend, registered, held until next result
//   out_valid  out  1   one-cycle pulse marking a new A
//   busy       out  1   high while a request is in progress (CALC/DONE)
//   err        out  1   R >= B consistency flag (CONSISTENCY_CHECK_EN only)
// ---------------------------------------------------------------------------
module div_recon (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  Q,
    input  logic [7:0]  B,
    input  logic [7:0]  R,
    output logic [15:0] A,
    output logic        out_valid,
    output logic        busy
`ifdef CONSISTENCY_CHECK_EN
    ,
    output logic        err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [7:0]  r_Q;
    logic [7:0]  r_B;
    logic [15:0] r_acc;
    logic [3:0]  r_cnt;
    logic [15:0] r_A;
    logic        r_out_valid;

    logic        w_accept;
    logic        w_step;
    logic        w_finish;
    logic [15:0] w_addend;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and per-state control strobes
    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_finish = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept = 1'b1;
                    w_next   = CALC;
                end
            end
            CALC: begin
                w_step = 1'b1;
                // The last quotient bit (index 7) is consumed on this edge.
                if (r_cnt == 4'd7) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                w_finish = 1'b1;
                w_next   = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Partial product for the current quotient bit. B is shifted by at most
    // 7 places, so it always fits in 16 bits.
    assign w_addend = r_Q[r_cnt[2:0]] ? ({8'h00, r_B} << r_cnt[2:0]) : '0;

    // Datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_Q         <= '0;
            r_B         <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_A         <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= w_finish;
            if (w_accept) begin
                r_Q   <= Q;
                r_B   <= B;
                r_acc <= {8'h00, R};
                r_cnt <= '0;
            end
            if (w_step) begin
                r_acc <= r_acc + w_addend;
                r_cnt <= r_cnt + 4'd1;
            end
            if (w_finish) begin
                r_A <= r_acc;
            end
        end
    end

`ifdef CONSISTENCY_CHECK_EN
    logic [7:0] r_R;
    logic       r_err;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_R   <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_R <= R;
            end
            if (w_finish) begin
                r_err <= (r_R >= r_B);
            end
        end
    end

    assign err = r_err;
`endif

    assign A         = r_A;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != IDLE);

endmodule
